// File: rtl/sync_pulse_rx_pkg.sv
// Shared constants for the toggle-based pulse crossing (receive side and
// the matching sender).
package sync_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int CNT_W_DEFAULT   = 4;

endpackage

// File: rtl/sync_pulse_rx_if.sv
// Event delivery handshake: the receiver drives valid/pending, the local
// consumer drives ready.
interface sync_pulse_rx_if
    import sync_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
);

    logic             evt_valid;
    logic             evt_ready;
    logic [CNT_W-1:0] pending;

    modport master (
        output evt_valid,
        output pending,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  pending,
        output evt_ready
    );

endinterface

// File: rtl/sync_pulse_rx_chain.sv
// N-flop asynchronous-reset level synchronizer. Also used by the sender to
// bring ack_tog back into its own domain.
module sync_chain #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE", keep = "true" *) logic [N-1:0] sync;

    // Shift the asynchronous level through the chain; only the last stage is safe to use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[N-2:0], d};
        end
    end

    assign q = sync[N-1];

endmodule

// File: rtl/sync_pulse_rx.sv
// Receive end of the toggle-based pulse crossing: synchronizes the remote
// toggle, turns each flip into a queued event, delivers events over a
// valid/ready handshake and returns an acknowledge toggle to the sender.
module sync_pulse_rx
    import sync_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tog_in,
    sync_pulse_rx_if.master evt,
    output logic            ack_tog,
    output logic            overflow,
    input  logic            ovf_clr
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX || CNT_W < 1) begin : g_param_check
        $fatal(1, "sync_pulse_rx: illegal SYNC_STAGES or CNT_W");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             lvl_s;
    logic             lvl_d;
    logic             tog_edge;
    logic             accept;
    logic             ovf_set;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    sync_chain #(
        .N(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (tog_in),
        .q     (lvl_s)
    );

    // Remember the previous synchronized level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_d <= 1'b0;
        end else begin
            lvl_d <= lvl_s;
        end
    end

    assign tog_edge      = lvl_s ^ lvl_d;
    assign evt.evt_valid = (cnt != '0);
    assign evt.pending   = cnt;
    assign accept        = evt.evt_valid && evt.evt_ready;

    // Next pending count; an edge with nowhere to go is flagged as a drop.
    always_comb begin
        cnt_nxt = cnt;
        ovf_set = 1'b0;
        if (tog_edge && !accept) begin
            if (cnt != CNT_MAX) begin
                cnt_nxt = cnt + 1'b1;
            end else begin
                ovf_set = 1'b1;
            end
        end else if (!tog_edge && accept) begin
            cnt_nxt = cnt - 1'b1;
        end
    end

    // Pending counter, acknowledge toggle and sticky overflow (set wins over clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            ack_tog  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            ack_tog <= ack_tog ^ accept;
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_pulse_rx.sv
// Self-checking bench for sync_pulse_rx: directed scenarios plus a random
// asynchronous-sender run scored against event counts.
module tb_sync_pulse_rx;
    import sync_pkg::*;

    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + 1;
    localparam int CNT_W2      = 2;
    localparam int NTOG        = 40;

    logic clk      = 1'b0;
    logic tclk     = 1'b0;
    logic rst_n    = 1'b0;
    logic tog_in   = 1'b0;
    logic tog2     = 1'b0;
    logic ovf_clr  = 1'b0;
    logic ovf_clr2 = 1'b0;
    logic ack_tog, overflow, ack2, ovf2;

    int   tests = 0;
    int   fails = 0;
    logic exp_ack = 1'b0;

    sync_pulse_rx_if #(.CNT_W(CNT_W_DEFAULT)) evt_if ();
    sync_pulse_rx_if #(.CNT_W(CNT_W2))        evt2_if ();

    sync_pulse_rx #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W_DEFAULT)) dut (
        .clk(clk), .rst_n(rst_n), .tog_in(tog_in), .evt(evt_if),
        .ack_tog(ack_tog), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    sync_pulse_rx #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W2)) dut2 (
        .clk(clk), .rst_n(rst_n), .tog_in(tog2), .evt(evt2_if),
        .ack_tog(ack2), .overflow(ovf2), .ovf_clr(ovf_clr2)
    );

    // Receive clock and an unrelated sender clock (frequency ratio 0.37).
    always #37 clk = ~clk;
    initial begin
        #17;
        forever #100 tclk = ~tclk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tog_in = 1'b0;
        tog2 = 1'b0;
        evt_if.evt_ready = 1'b0;
        evt2_if.evt_ready = 1'b0;
        repeat (5) step();
        tests += 6;
        if (evt_if.pending !== '0) begin fails++; $display("FAIL reset_pending got=%0d want=0", evt_if.pending); end
        if (evt_if.evt_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b want=0", evt_if.evt_valid); end
        if (ack_tog !== 1'b0) begin fails++; $display("FAIL reset_ack got=%b want=0", ack_tog); end
        if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got=%b want=0", overflow); end
        if (evt2_if.pending !== '0) begin fails++; $display("FAIL reset_pending2 got=%0d want=0", evt2_if.pending); end
        if (ovf2 !== 1'b0) begin fails++; $display("FAIL reset_ovf2 got=%b want=0", ovf2); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_ack = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_single();
        logic ack0;
        ack0 = exp_ack;
        evt_if.evt_ready = 1'b1;
        step();
        tog_in = ~tog_in;
        for (int k = 1; k <= LAT + 2; k++) begin
            step();
            tests += 3;
            if (evt_if.evt_valid !== (k == LAT)) begin
                fails++; $display("FAIL single_valid k=%0d got=%b want=%b", k, evt_if.evt_valid, (k == LAT));
            end
            if (evt_if.pending !== ((k == LAT) ? 4'd1 : 4'd0)) begin
                fails++; $display("FAIL single_pending k=%0d got=%0d", k, evt_if.pending);
            end
            if (ack_tog !== (ack0 ^ (k > LAT))) begin
                fails++; $display("FAIL single_ack k=%0d got=%b want=%b", k, ack_tog, ack0 ^ (k > LAT));
            end
        end
        exp_ack = ack0 ^ 1'b1;
        evt_if.evt_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        evt_if.evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tog_in = ~tog_in;
            repeat (4) step();
        end
        step();
        tests += 2;
        if (evt_if.pending !== 4'd5) begin fails++; $display("FAIL bp_pending got=%0d want=5", evt_if.pending); end
        if (evt_if.evt_valid !== 1'b1) begin fails++; $display("FAIL bp_valid got=%b want=1", evt_if.evt_valid); end
        evt_if.evt_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            exp_ack = ~exp_ack;
            tests += 2;
            if (int'(evt_if.pending) !== 5 - k) begin
                fails++; $display("FAIL bp_drain k=%0d got=%0d want=%0d", k, evt_if.pending, 5 - k);
            end
            if (ack_tog !== exp_ack) begin
                fails++; $display("FAIL bp_ack k=%0d got=%b want=%b", k, ack_tog, exp_ack);
            end
        end
        evt_if.evt_ready = 1'b0;
        step();
        tests += 2;
        if (evt_if.evt_valid !== 1'b0) begin fails++; $display("FAIL bp_empty_valid got=%b want=0", evt_if.evt_valid); end
        if (ack_tog !== exp_ack) begin fails++; $display("FAIL bp_ack_hold got=%b want=%b", ack_tog, exp_ack); end
    endtask

    task automatic test_simultaneous();
        evt_if.evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tog_in = ~tog_in;
            repeat (4) step();
        end
        tests++;
        if (evt_if.pending !== 4'd3) begin fails++; $display("FAIL simul_pre got=%0d want=3", evt_if.pending); end
        tog_in = ~tog_in;
        repeat (LAT - 1) step();
        evt_if.evt_ready = 1'b1;
        step();
        evt_if.evt_ready = 1'b0;
        exp_ack = ~exp_ack;
        tests += 3;
        if (evt_if.pending !== 4'd3) begin fails++; $display("FAIL simul_pending got=%0d want=3", evt_if.pending); end
        if (ack_tog !== exp_ack) begin fails++; $display("FAIL simul_ack got=%b want=%b", ack_tog, exp_ack); end
        if (overflow !== 1'b0) begin fails++; $display("FAIL simul_ovf got=%b want=0", overflow); end
        evt_if.evt_ready = 1'b1;
        repeat (3) step();
        evt_if.evt_ready = 1'b0;
        exp_ack = ~exp_ack;
        tests += 2;
        if (evt_if.pending !== 4'd0) begin fails++; $display("FAIL simul_drain got=%0d want=0", evt_if.pending); end
        if (ack_tog !== exp_ack) begin fails++; $display("FAIL simul_drain_ack got=%b want=%b", ack_tog, exp_ack); end
    endtask

    task automatic test_saturation();
        evt2_if.evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tog2 = ~tog2;
            repeat (4) step();
            if (i >= 2) begin
                tests += 2;
                if (evt2_if.pending !== 2'd3) begin
                    fails++; $display("FAIL sat_pending i=%0d got=%0d want=3", i, evt2_if.pending);
                end
                if (ovf2 !== (i == 3)) begin
                    fails++; $display("FAIL sat_ovf i=%0d got=%b want=%b", i, ovf2, (i == 3));
                end
            end
        end
        ovf_clr2 = 1'b1;
        step();
        ovf_clr2 = 1'b0;
        tests++;
        if (ovf2 !== 1'b0) begin fails++; $display("FAIL sat_clear got=%b want=0", ovf2); end
        tog2 = ~tog2;
        repeat (LAT - 1) step();
        ovf_clr2 = 1'b1;
        step();
        ovf_clr2 = 1'b0;
        tests += 2;
        if (ovf2 !== 1'b1) begin fails++; $display("FAIL sat_set_wins got=%b want=1", ovf2); end
        if (evt2_if.pending !== 2'd3) begin fails++; $display("FAIL sat_hold got=%0d want=3", evt2_if.pending); end
        evt2_if.evt_ready = 1'b1;
        repeat (3) step();
        evt2_if.evt_ready = 1'b0;
        ovf_clr2 = 1'b1;
        step();
        ovf_clr2 = 1'b0;
        tests += 2;
        if (evt2_if.pending !== 2'd0) begin fails++; $display("FAIL sat_drain got=%0d want=0", evt2_if.pending); end
        if (ovf2 !== 1'b0) begin fails++; $display("FAIL sat_final_ovf got=%b want=0", ovf2); end
    endtask

    task automatic test_reset_mid();
        evt_if.evt_ready = 1'b1;
        tog_in = ~tog_in;
        repeat (LAT + 2) step();
        evt_if.evt_ready = 1'b0;
        exp_ack = ~exp_ack;
        for (int i = 0; i < 4; i++) begin
            tog_in = ~tog_in;
            tog2 = ~tog2;
            repeat (4) step();
        end
        tests += 4;
        if (evt_if.pending !== 4'd4) begin fails++; $display("FAIL rmid_pre_pending got=%0d want=4", evt_if.pending); end
        if (ack_tog !== exp_ack) begin fails++; $display("FAIL rmid_pre_ack got=%b want=%b", ack_tog, exp_ack); end
        if (ovf2 !== 1'b1) begin fails++; $display("FAIL rmid_pre_ovf2 got=%b want=1", ovf2); end
        if (evt2_if.pending !== 2'd3) begin fails++; $display("FAIL rmid_pre_pending2 got=%0d want=3", evt2_if.pending); end
        #20;
        rst_n = 1'b0;
        tog_in = 1'b0;
        tog2 = 1'b0;
        #5;
        exp_ack = 1'b0;
        tests += 5;
        if (evt_if.pending !== '0) begin fails++; $display("FAIL rmid_pending got=%0d want=0", evt_if.pending); end
        if (evt_if.evt_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid got=%b want=0", evt_if.evt_valid); end
        if (ack_tog !== 1'b0) begin fails++; $display("FAIL rmid_ack got=%b want=0", ack_tog); end
        if (overflow !== 1'b0) begin fails++; $display("FAIL rmid_ovf got=%b want=0", overflow); end
        if (ovf2 !== 1'b0) begin fails++; $display("FAIL rmid_ovf2 got=%b want=0", ovf2); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_random();
        int   sent = 0;
        int   acc = 0;
        bit   sender_done = 0;
        bit   stop = 0;
        bit   drained = 0;
        logic ack0;
        ack0 = exp_ack;
        fork
            begin
                for (int i = 0; i < NTOG; i++) begin
                    repeat (LAT + $urandom_range(0, 3)) @(posedge tclk);
                    #1;
                    tog_in = ~tog_in;
                    sent++;
                end
                sender_done = 1;
            end
            begin
                while (!sender_done) begin
                    step();
                    evt_if.evt_ready = 1'($urandom_range(0, 1));
                end
                repeat (LAT + 4) step();
                evt_if.evt_ready = 1'b1;
                for (int c = 0; c < 64 && !drained; c++) begin
                    @(negedge clk);
                    drained = (evt_if.pending == '0);
                end
                stop = 1;
            end
            begin
                while (!stop) begin
                    @(negedge clk);
                    tests += 2;
                    if (overflow !== 1'b0) begin
                        fails++; $display("FAIL rand_ovf got=%b want=0", overflow);
                    end
                    if (int'(evt_if.pending) > sent - acc) begin
                        fails++; $display("FAIL rand_excess pending=%0d max=%0d", evt_if.pending, sent - acc);
                    end
                    if (evt_if.evt_valid && evt_if.evt_ready) acc++;
                end
            end
        join
        evt_if.evt_ready = 1'b0;
        exp_ack = ack0 ^ NTOG[0];
        step();
        tests += 4;
        if (!drained) begin fails++; $display("FAIL rand_drain_timeout pending=%0d want=0", evt_if.pending); end
        if (acc !== NTOG) begin fails++; $display("FAIL rand_count accepted=%0d want=%0d", acc, NTOG); end
        if (ack_tog !== exp_ack) begin fails++; $display("FAIL rand_ack_parity got=%b want=%b", ack_tog, exp_ack); end
        if (overflow !== 1'b0) begin fails++; $display("FAIL rand_final_ovf got=%b want=0", overflow); end
    endtask

    initial begin
        evt_if.evt_ready = 1'b0;
        evt2_if.evt_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_simultaneous();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sync_pulse_rx.md
Name: sync_pulse_rx

Overview:
- Receive end of the toggle-based pulse crossing.
- A remote domain flips a level once per event; this block synchronizes that level into `clk`, detects each flip and queues it as a pending event.
- Events are delivered to local logic over a valid/ready handshake.
- An acknowledge toggle goes back to the sender, so the sender can rate-limit and no event is lost when events arrive back-to-back.

Parameters:
- SYNC_STAGES, 2, flip-flops in the synchronizer chain (legal: 2..4).
- CNT_W, 4, width of the pending-event counter; max pending = 2**CNT_W-1.

Ports:
- clk  in  1  receive-domain clock.
- rst_n  in  1  asynchronous active-low reset.
- tog_in  in  1  event toggle from remote domain, asynchronous to clk; one transition = one event.
- evt_valid  out  1  at least one event is pending.
- evt_ready  in  1  consumer accepts an event when evt_valid&&evt_ready.
- pending  out  CNT_W  current pending-event count.
- ack_tog  out  1  toggles once per accepted event; for return crossing to the sender.
- overflow  out  1  sticky: an event was dropped.
- ovf_clr  in  1  single-cycle clear of overflow.

Behaviour:
- Reset values (rst_n low, async assert, sync deassert by the system): synchronizer chain=0, edge-detect register=0, pending=0, evt_valid=0, ack_tog=0, overflow=0.
- Sender contract: sender's toggle resets to 0. A tog_in of 1 at reset release is detected as one event; this is intended.
- Synchronizer: sync[0]<=tog_in, sync[i]<=sync[i-1]. Only sync[SYNC_STAGES-1] is used downstream.
- Edge detect: lvl_d<=sync[SYNC_STAGES-1]; edge = sync[SYNC_STAGES-1]^lvl_d (combinational, one cycle wide).
- Latency: tog_in transition to evt_valid high is SYNC_STAGES+1 clk edges (3 at default), plus up to 1 cycle of metastability uncertainty.
- accept = evt_valid && evt_ready.
- Counter update, registered each cycle:
  - edge && !accept && pending!=MAX: pending+1.
  - !edge && accept: pending-1.
  - edge && accept: unchanged, including at MAX.
  - edge && !accept && pending==MAX: unchanged, overflow<=1 (event dropped).
- evt_valid = (pending!=0), taken from the registered counter. No combinational path from evt_ready to evt_valid.
- ack_tog <= ack_tog ^ accept, registered.
- Overflow: set has priority over clear when both occur in one cycle. ovf_clr alone clears it. Overflow does not block further counting.
- Throughput: one accepted event per cycle max. Edges arrive at most once per cycle. Sender must space toggles by at least SYNC_STAGES+1 of the slower clock period for them to be resolved individually; this is guaranteed by acks.
- Reset mid-operation: all pending events are discarded. ack_tog returns to 0; the sender must be reset in the same system reset.
- Elaboration check: SYNC_STAGES<2 or CNT_W<1 is a fatal error.

Decomposition:
- Shared package sync_pkg:
  - SYNC_STAGES_MIN=2, SYNC_STAGES_MAX=4.
  - Default CNT_W constant.
- One sub-module, sync_chain (parameter N; ports clk, rst_n, d, q): an N-flop async-reset level synchronizer carrying the synthesis keep/async-reg attribute. It is reusable by the matching sender for the ack_tog return path.

Test Plan:
- Reset then single toggle: rst_n low 5 cycles, release, tog_in 0->1 at cycle 10 with evt_ready=1 → evt_valid high at cycle 13 for exactly 1 cycle; ack_tog 0->1 at cycle 14; pending returns to 0.
- Backpressure queueing: evt_ready=0, 5 toggles spaced 4 cycles → pending=5, evt_valid=1. Then evt_ready=1 → exactly 5 accepts on consecutive cycles, ack_tog toggles 5 times (final 1), pending=0.
- Simultaneous edge and accept: pending=3, edge arrives in the same cycle as accept → pending stays 3, ack_tog toggles, overflow=0.
- Saturation: CNT_W=2, evt_ready=0, 4 toggles → pending=3, overflow=1 after the 4th edge. Then ovf_clr pulse → overflow=0. Then ovf_clr coincident with a 5th dropped edge → overflow remains 1.
- Reset mid-operation: pending=4, assert rst_n mid-cycle → pending, evt_valid, ack_tog, overflow all 0 immediately, without waiting for a clk edge.
- Random asynchronous tog_in (unrelated clock ratio 0.37, min spacing honored), random evt_ready → scoreboard: accepted count == toggle count, ack_tog parity == accepted parity, overflow never set.
